// File: rtl/cmd_queue_loader_if.sv
// Beat-link and command-FIFO write signals seen by the command queue loader.
// The loader takes the slave view; the beat source / FIFO side takes the master view.
interface cmd_queue_loader_if #(
  parameter int CMD_W = 64,
  parameter int IN_W  = 8,
  parameter int CNT_W = 16
);
  logic             i_valid;
  logic [IN_W-1:0]  i_data;
  logic             i_last;
  logic             o_ready;
  logic             i_fifo_full;
  logic             o_fifo_write;
  logic [CMD_W-1:0] o_fifo_data;
  logic [CNT_W-1:0] o_cmd_count;
  logic             o_done;
  logic             o_err;

  modport slave (
    input  i_valid, i_data, i_last, i_fifo_full,
    output o_ready, o_fifo_write, o_fifo_data, o_cmd_count, o_done, o_err
  );

  modport master (
    output i_valid, i_data, i_last, i_fifo_full,
    input  o_ready, o_fifo_write, o_fifo_data, o_cmd_count, o_done, o_err
  );
endinterface

// File: rtl/cmd_queue_loader.sv
// Command queue loader: packs IN_W-bit beats (little-endian) into CMD_W-bit
// command words and pushes each completed word into the command FIFO,
// stalling while the FIFO reports full.
module cmd_queue_loader #(
  parameter int CMD_W = 64,
  parameter int IN_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  cmd_queue_loader_if.slave bus
);
  localparam int BEATS = (CMD_W + IN_W - 1) / IN_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ACC_W = BEATS * IN_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic {
    COLLECT,
    PUSH
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] word;
  logic             pend_done;
  logic [CMD_W-1:0] fifo_data;
  logic [CNT_W-1:0] cmd_count;
  logic             done;
  logic             err;

  // Full word as it would look if the current beat were the final one.
  always_comb begin
    word = acc;
    word[(BEATS-1)*IN_W +: IN_W] = bus.i_data;
  end

  // Final-beat bits above CMD_W are deliberately dropped.
  if (ACC_W > CMD_W) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^word[ACC_W-1:CMD_W];
  end

  // Beat collection, FIFO push handshake, counter and status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= COLLECT;
      idx       <= '0;
      acc       <= '0;
      fifo_data <= '0;
      cmd_count <= '0;
      pend_done <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (bus.i_valid) begin
            if (idx == LAST_IDX) begin
              fifo_data <= word[CMD_W-1:0];
              pend_done <= bus.i_last;
              idx       <= '0;
              state     <= PUSH;
            end else if (bus.i_last) begin
              // Early i_last: drop the partial word; stale acc bits are
              // overwritten beat by beat before they can be reused.
              err <= 1'b1;
              idx <= '0;
            end else begin
              acc[idx*IN_W +: IN_W] <= bus.i_data;
              idx                   <= idx + 1'b1;
            end
          end
        end
        PUSH: begin
          if (!bus.i_fifo_full) begin
            cmd_count <= cmd_count + 1'b1;
            done      <= pend_done;
            pend_done <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.o_ready      = (state == COLLECT);
  assign bus.o_fifo_write = (state == PUSH) && !bus.i_fifo_full;
  assign bus.o_fifo_data  = fifo_data;
  assign bus.o_cmd_count  = cmd_count;
  assign bus.o_done       = done;
  assign bus.o_err        = err;
endmodule
